// File: rtl/uart_rx_if.sv
// Byte-stream side of the UART receiver: AXI-Stream style byte handshake plus
// single-cycle error strobes.
interface uart_rx_if;
  logic [7:0] axis_tdata;
  logic       axis_tvalid;
  logic       axis_tready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output axis_tdata,
    output axis_tvalid,
    output frame_err,
    output overrun,
    input  axis_tready
  );

  modport slave (
    input  axis_tdata,
    input  axis_tvalid,
    input  frame_err,
    input  overrun,
    output axis_tready
  );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// reset value so an idle-high line does not look like a start bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-deep AXI-Stream style
// output register with overrun and framing-error strobes.
module uart_rx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx_data,
  uart_rx_if.master axis
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  logic               rx_s;
  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [2:0]         idx, idx_n;
  logic [7:0]         shreg, shreg_n;
  logic               vld_p1, vld_n;
  logic               err_p1, err_n;

  // stage 0: synchronize the raw line
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_data),
    .q   (rx_s)
  );

  // stage 1: bit-timing FSM, produces a completed byte or a framing error
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      shreg  <= '0;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      vld_p1 <= vld_n;
      err_p1 <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer + TIMER_W'(1);
    idx_n   = idx;
    shreg_n = shreg;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (timer == HALF_LAST) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timer_n        = '0;
          shreg_n[idx]   = rx_s;
          idx_n          = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (timer == BIT_LAST) begin
          timer_n = '0;
          if (rx_s) begin
            vld_n   = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        // line held low after a bad stop bit; wait for it to release
        timer_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // stage 2: output holding register and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      axis.axis_tdata  <= 8'h00;
      axis.axis_tvalid <= 1'b0;
      axis.frame_err   <= 1'b0;
      axis.overrun     <= 1'b0;
    end else begin
      axis.frame_err <= err_p1;
      axis.overrun   <= 1'b0;
      if (vld_p1) begin
        if (axis.axis_tvalid && !axis.axis_tready) begin
          axis.overrun <= 1'b1;
        end else begin
          axis.axis_tdata  <= shreg;
          axis.axis_tvalid <= 1'b1;
        end
      end else if (axis.axis_tvalid && axis.axis_tready) begin
        axis.axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: the stimulus side pushes
// expected bytes, a negedge monitor pops them on every handshake.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int   mode = 1;  // tready: 0 low, 1 high, 2 random
  int   cyc  = 0;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(160), .BAUD_RATE(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx),
    .axis    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    case (mode)
      0:       bus.axis_tready = 1'b0;
      1:       bus.axis_tready = 1'b1;
      default: bus.axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  int        tests = 0;
  int        fails = 0;
  logic [7:0] exp_q[$];
  int        n_rise = 0, n_ferr = 0, n_ovr = 0;
  bit        prev_vld = 1'b0;
  bit        lat_armed = 1'b0;
  int        start_cyc = 0;
  int        lat_meas = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts strobes and scores every accepted byte
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.axis_tvalid && !prev_vld) begin
        n_rise++;
        if (lat_armed) begin
          lat_meas  = cyc - start_cyc;
          lat_armed = 1'b0;
        end
      end
      if (bus.frame_err) n_ferr++;
      if (bus.overrun)   n_ovr++;
      if (bus.axis_tvalid && bus.axis_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h, expected no byte", bus.axis_tdata);
        end else begin
          check("rx_byte", 32'(bus.axis_tdata), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_vld = bus.axis_tvalid;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(bus.axis_tvalid), 32'd0);
    check({tag, "_tdata"},  32'(bus.axis_tdata),  32'd0);
    check({tag, "_ferr"},   32'(bus.frame_err),   32'd0);
    check({tag, "_ovr"},    32'(bus.overrun),     32'd0);
  endtask

  int r0, f0, o0;

  initial begin
    // Reset values
    repeat (4) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(10);

    // Single good frame, latency and no error strobes
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'h41);
    start_cyc = cyc + 1;
    lat_armed = 1'b1;
    send_frame(8'h41, 1'b1);
    idle(20);
    check("lat_0x41",    32'(lat_meas),      32'(LAT));
    check("rises_0x41",  32'(n_rise - r0),   32'd1);
    check("ferr_0x41",   32'(n_ferr - f0),   32'd0);
    check("ovr_0x41",    32'(n_ovr - o0),    32'd0);
    check("tvalid_0x41", 32'(bus.axis_tvalid), 32'd0);

    // Short glitch on the line
    r0 = n_rise; f0 = n_ferr;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    check("glitch_rises", 32'(n_rise - r0), 32'd0);
    check("glitch_ferr",  32'(n_ferr - f0), 32'd0);

    // Bad stop bit, line held low, then recovery
    r0 = n_rise; f0 = n_ferr;
    send_frame(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    idle(20);
    check("break_ferr",  32'(n_ferr - f0), 32'd1);
    check("break_rises", 32'(n_rise - r0), 32'd0);
    r0 = n_rise;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("resume_rises", 32'(n_rise - r0), 32'd1);

    // Back-to-back frames with the consumer stalled
    mode = 0;
    idle(2);
    o0 = n_ovr;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle(20);
    check("stall_ovr",    32'(n_ovr - o0),      32'd1);
    check("stall_tdata",  32'(bus.axis_tdata),  32'h55);
    check("stall_tvalid", 32'(bus.axis_tvalid), 32'd1);
    mode = 1;
    idle(5);
    check("drain_tvalid", 32'(bus.axis_tvalid), 32'd0);
    check("drain_q",      32'(exp_q.size()),    32'd0);

    // Reset in the middle of bit 3 of 0x3C
    r0 = n_rise; f0 = n_ferr;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h3C >> i));
    rx = 1'(8'h3C >> 3);
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    idle(40);
    check("midrst_rises", 32'(n_rise - r0), 32'd0);
    check("midrst_ferr",  32'(n_ferr - f0), 32'd0);
    r0 = n_rise;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(20);
    check("after_rst_rises", 32'(n_rise - r0), 32'd1);

    // Back-to-back 'A'..'Z' with random tready
    f0 = n_ferr; o0 = n_ovr;
    mode = 2;
    for (int c = 8'h41; c <= 8'h5A; c++) begin
      exp_q.push_back(8'(c));
      send_frame(8'(c), 1'b1);
    end
    idle(20);
    mode = 1;
    idle(20);
    check("stream_q",    32'(exp_q.size()), 32'd0);
    check("stream_ferr", 32'(n_ferr - f0),  32'd0);
    check("stream_ovr",  32'(n_ovr - o0),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
